// File: rtl/ajuste_tiempo_rep.sv
// ajuste_tiempo_rep
// -----------------
// Time-setting counter driven by two bouncing push buttons. Each button is
// sampled on a slow tick through a 3-flop chain (debounce plus edge detect).
// A press steps the value once. Holding the button starts auto-repeat after
// REP_DELAY ticks, then steps every REP_RATE ticks. The value stays within
// 0..VAL_MAX and wraps at both ends.
//
// Optional feature: define AJUSTE_SATURAR_EN to make the arithmetic saturate
// at 0 and VAL_MAX instead of wrapping. A step that does not change the value
// produces no pulso_cambio.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_arriba   raw increment button (asynchronous, bouncing)
//   btn_abajo    raw decrement button (asynchronous, bouncing)
//   switch_en    block enable; 0 forces the value to 0
//   tiempo_out   current programmed value (registered)
//   pulso_cambio one-clk pulse in the first cycle tiempo_out shows a new value
//   en_max       tiempo_out == VAL_MAX (registered)
//   en_cero      tiempo_out == 0 (registered)

module ajuste_tiempo_rep #(
  parameter int WIDTH     = 5,
  parameter int VAL_MAX   = 20,
  parameter int CLK_DIV   = 250000,
  parameter int REP_DELAY = 100,
  parameter int REP_RATE  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_arriba,
  input  logic             btn_abajo,
  input  logic             switch_en,
  output logic [WIDTH-1:0] tiempo_out,
  output logic             pulso_cambio,
  output logic             en_max,
  output logic             en_cero
);

  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [WIDTH-1:0] VMAX       = WIDTH'(VAL_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REP_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // One step of the value arithmetic in the selected mode.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v,
                                                input logic up);
    logic [WIDTH-1:0] r;
`ifdef AJUSTE_SATURAR_EN
    if (up) begin
      r = (v >= VMAX) ? VMAX : v + WIDTH'(1);
    end else begin
      r = (v == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : v - WIDTH'(1);
    end
`else
    if (up) begin
      r = (v >= VMAX) ? {WIDTH{1'b0}} : v + WIDTH'(1);
    end else begin
      r = (v == {WIDTH{1'b0}}) ? VMAX : v - WIDTH'(1);
    end
`endif
    return r;
  endfunction

  logic [CNT_W-1:0] div_cnt_r;
  logic             tick_s;
  logic [2:0]       up_sh_r;   // [0]=s0, [1]=s1, [2]=s2
  logic [2:0]       dn_sh_r;
  logic             press_up_s, press_dn_s, held_up_s, held_dn_s;
  logic             held_own_s, held_other_s;
  state_t           state_r, state_nxt_s;
  logic [REP_W-1:0] rep_cnt_r, rep_cnt_nxt_s;
  logic             dir_up_r, dir_up_nxt_s;
  logic             do_step_s, step_up_s;
  logic [WIDTH-1:0] val_nxt_s;

  assign tick_s = (div_cnt_r == CNT_LAST);

  // Free-running sampling-tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {CNT_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + CNT_W'(1);
    end
  end

  // Button sampler chains; they keep running while the block is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sh_r <= 3'b000;
      dn_sh_r <= 3'b000;
    end else if (tick_s) begin
      up_sh_r <= {up_sh_r[1:0], btn_arriba};
      dn_sh_r <= {dn_sh_r[1:0], btn_abajo};
    end else begin
      up_sh_r <= up_sh_r;
      dn_sh_r <= dn_sh_r;
    end
  end

  assign press_up_s   = up_sh_r[1] & ~up_sh_r[2] & tick_s;
  assign press_dn_s   = dn_sh_r[1] & ~dn_sh_r[2] & tick_s;
  assign held_up_s    = up_sh_r[1] & up_sh_r[2];
  assign held_dn_s    = dn_sh_r[1] & dn_sh_r[2];
  assign held_own_s   = dir_up_r ? held_up_s : held_dn_s;
  assign held_other_s = dir_up_r ? held_dn_s : held_up_s;

  // Step decision and next FSM state; the FSM only moves on a tick.
  always_comb begin
    state_nxt_s   = state_r;
    rep_cnt_nxt_s = rep_cnt_r;
    dir_up_nxt_s  = dir_up_r;
    do_step_s     = 1'b0;
    step_up_s     = dir_up_r;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          // Simultaneous presses cancel each other.
          if (press_up_s ^ press_dn_s) begin
            do_step_s     = 1'b1;
            step_up_s     = press_up_s;
            dir_up_nxt_s  = press_up_s;
            rep_cnt_nxt_s = {REP_W{1'b0}};
            state_nxt_s   = HOLD;
          end else begin
            state_nxt_s   = IDLE;
          end
        end
        HOLD, REPEAT: begin
          // The opposite button takes priority and aborts without a step.
          if (held_other_s || !held_own_s) begin
            rep_cnt_nxt_s = {REP_W{1'b0}};
            state_nxt_s   = IDLE;
          end else if (rep_cnt_r == ((state_r == HOLD) ? DELAY_LAST : RATE_LAST)) begin
            do_step_s     = 1'b1;
            rep_cnt_nxt_s = {REP_W{1'b0}};
            state_nxt_s   = REPEAT;
          end else begin
            rep_cnt_nxt_s = rep_cnt_r + REP_W'(1);
          end
        end
        default: begin
          rep_cnt_nxt_s = {REP_W{1'b0}};
          state_nxt_s   = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign val_nxt_s = do_step_s ? step_val(tiempo_out, step_up_s) : tiempo_out;

  // FSM state, repeat counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rep_cnt_r    <= {REP_W{1'b0}};
      dir_up_r     <= 1'b0;
      tiempo_out   <= {WIDTH{1'b0}};
      pulso_cambio <= 1'b0;
      en_max       <= 1'b0;
      en_cero      <= 1'b1;
    end else if (!switch_en) begin
      state_r      <= IDLE;
      rep_cnt_r    <= {REP_W{1'b0}};
      dir_up_r     <= dir_up_r;
      tiempo_out   <= {WIDTH{1'b0}};
      pulso_cambio <= (tiempo_out != {WIDTH{1'b0}});
      en_max       <= 1'b0;   // VAL_MAX is at least 1, so 0 is never the max
      en_cero      <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      rep_cnt_r    <= rep_cnt_nxt_s;
      dir_up_r     <= dir_up_nxt_s;
      tiempo_out   <= val_nxt_s;
      pulso_cambio <= (val_nxt_s != tiempo_out);
      en_max       <= (val_nxt_s == VMAX);
      en_cero      <= (val_nxt_s == {WIDTH{1'b0}});
    end
  end

endmodule

// File: tb/tb_ajuste_tiempo_rep.sv
// Testbench for ajuste_tiempo_rep. Expected values are queued when a
// stimulus is driven and compared against the DUT whenever pulso_cambio
// fires. Button activity is driven in whole tick periods (CLK_DIV clocks),
// so each hold covers an exact number of sampling ticks.

module tb_ajuste_tiempo_rep;

  localparam int WIDTH     = 5;
  localparam int VAL_MAX   = 20;
  localparam int CLK_DIV   = 4;
  localparam int REP_DELAY = 3;
  localparam int REP_RATE  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_arriba = 1'b0;
  logic             btn_abajo = 1'b0;
  logic             switch_en = 1'b0;
  logic [WIDTH-1:0] tiempo_out;
  logic             pulso_cambio;
  logic             en_max;
  logic             en_cero;

  ajuste_tiempo_rep #(
    .WIDTH(WIDTH), .VAL_MAX(VAL_MAX), .CLK_DIV(CLK_DIV),
    .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_arriba(btn_arriba), .btn_abajo(btn_abajo),
    .switch_en(switch_en), .tiempo_out(tiempo_out), .pulso_cambio(pulso_cambio),
    .en_max(en_max), .en_cero(en_cero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int model_val = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every pulse must match the oldest queued value.
  always @(negedge clk) begin
    if (rst_n && pulso_cambio) begin
      check_eq("pulse_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        check_eq("sb_value", tiempo_out, e);
        check_eq("sb_en_max", en_max, e == VAL_MAX);
        check_eq("sb_en_cero", en_cero, e == 0);
      end
    end
  end

  function automatic int step_m(input int v, input bit up);
`ifdef AJUSTE_SATURAR_EN
    if (up) return (v == VAL_MAX) ? v : v + 1;
    else    return (v == 0) ? 0 : v - 1;
`else
    if (up) return (v == VAL_MAX) ? 0 : v + 1;
    else    return (v == 0) ? VAL_MAX : v - 1;
`endif
  endfunction

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_step(input bit up);
    int nv;
    nv = step_m(model_val, up);
    if (nv != model_val) exp_q.push_back(nv);
    model_val = nv;
  endtask

  task automatic set_btn(input bit up, input logic lvl);
    if (up) btn_arriba = lvl;
    else    btn_abajo  = lvl;
  endtask

  // Hold one button for n ticks; steps at offsets 0, REP_DELAY, +REP_RATE...
  task automatic hold_btn(input bit up, input int n);
    int k;
    k = 0;
    while (k < n) begin
      push_step(up);
      k = (k == 0) ? REP_DELAY : k + REP_RATE;
    end
    set_btn(up, 1'b1);
    clocks(CLK_DIV * n);
    set_btn(up, 1'b0);
    clocks(CLK_DIV * 4);
  endtask

  task automatic press_once(input bit up);
    hold_btn(up, 2);
  endtask

  task automatic drain(input string tag);
    clocks(CLK_DIV * 2);
    check_eq({tag, "_queue"}, exp_q.size(), 0);
    check_eq({tag, "_val"}, tiempo_out, model_val);
  endtask

  initial begin
    switch_en = 1'b1;
    clocks(3);
    check_eq("rst_val", tiempo_out, 0);
    check_eq("rst_pulse", pulso_cambio, 0);
    check_eq("rst_en_max", en_max, 0);
    check_eq("rst_en_cero", en_cero, 1);
    rst_n = 1'b1;
    model_val = 0;

    // Single press 0 -> 1.
    press_once(1'b1);
    drain("first_up");
    check_eq("first_up_en_cero", en_cero, 0);

    // Up to VAL_MAX, then one more.
    for (int i = 0; i < VAL_MAX - 1; i++) press_once(1'b1);
    drain("to_max");
    check_eq("to_max_en_max", en_max, 1);
    press_once(1'b1);
    drain("past_max");

    // Down at 0.
    while (model_val != 0) press_once(1'b0);
    drain("at_zero");
    press_once(1'b0);
    drain("below_zero");

    // Auto-repeat from 5 over an 11-tick hold.
    while (model_val != 5) press_once(model_val < 5);
    drain("at_five");
    hold_btn(1'b1, 11);
    drain("hold_repeat");
    check_eq("hold_repeat_ten", tiempo_out, 10);

    // Both buttons rising on the same tick: no change.
    btn_arriba = 1'b1;
    btn_abajo  = 1'b1;
    clocks(CLK_DIV * 6);
    btn_arriba = 1'b0;
    btn_abajo  = 1'b0;
    clocks(CLK_DIV * 4);
    drain("both_same_tick");

    // Down pressed during up auto-repeat: three up steps, then abort.
    push_step(1'b1);
    push_step(1'b1);
    push_step(1'b1);
    btn_arriba = 1'b1;
    clocks(CLK_DIV * 6);
    btn_abajo = 1'b1;
    clocks(CLK_DIV * 4);
    btn_arriba = 1'b0;
    btn_abajo  = 1'b0;
    clocks(CLK_DIV * 4);
    drain("abort_repeat");
    check_eq("abort_repeat_13", tiempo_out, 13);

    // Disable at 7: one pulse to 0.
    while (model_val != 7) press_once(model_val < 7);
    drain("at_seven");
    exp_q.push_back(0);
    model_val = 0;
    switch_en = 1'b0;
    @(negedge clk);
    check_eq("en_off_val", tiempo_out, 0);
    check_eq("en_off_pulse", pulso_cambio, 1);
    clocks(4);
    check_eq("en_off_single_pulse", pulso_cambio, 0);

    // Enable rising with the button already held: no step until re-press.
    btn_arriba = 1'b1;
    clocks(CLK_DIV * 4);
    switch_en = 1'b1;
    clocks(CLK_DIV * 4);
    btn_arriba = 1'b0;
    clocks(CLK_DIV * 4);
    drain("en_rise_held");
    press_once(1'b1);
    drain("en_repress");

    // Reset in the middle of auto-repeat.
    push_step(1'b1);
    push_step(1'b1);
    btn_arriba = 1'b1;
    clocks(CLK_DIV * 6 + 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_val", tiempo_out, 0);
    check_eq("midrst_pulse", pulso_cambio, 0);
    check_eq("midrst_en_max", en_max, 0);
    check_eq("midrst_en_cero", en_cero, 1);
    check_eq("midrst_queue", exp_q.size(), 0);
    btn_arriba = 1'b0;
    model_val = 0;
    clocks(3);
    rst_n = 1'b1;
    clocks(CLK_DIV * 4);
    drain("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
